uart_autobaud: RTL

- Auto-baud controller that sequences the UART receiver.
- Measures a 0x55 ('U') sync character on the raw rxd line and computes the receiver's prescale value (bit time = prescale*8 clocks).
- Holds the receiver in reset until lock, then releases it.
- Monitors receiver frame errors and forces a re-measure when the link degrades.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rxd_sync.sv | 37 +++
 rtl/uart_autobaud.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the auto-baud controller and the UART receiver path.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        WAIT_START,
        MEASURE,
        CHECK,
        WAIT_STOP,
        LOCKED
    } ab_state_e;

    // A 0x55 character produces falling edges at the start bit and at bits 1, 3, 5 and 7,
    // so the first and fifth falling edges are eight bit times apart.
    localparam int SYNC_FALL_EDGES = 5;
    localparam int PRESCALE_SHIFT  = 6;
    localparam int PRESCALE_ROUND  = 32;

endpackage

// File: rtl/uart_rxd_sync.sv
// Two-flop synchroniser for the raw serial line with single-cycle rise/fall pulses.
module uart_rxd_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;
    logic meta_d, sync_d, prev_d;

    always_comb begin
        meta_d = rxd;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: the chain resets to 1 (idle line level) so that leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rxd_s = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud controller: measures a 0x55 sync character, derives the receiver prescale and
// gates the receiver reset. Optional start-bit plausibility check: UART_AUTOBAUD_EDGE_CHECK_EN.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int          CNT_WIDTH        = 22,
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd1,
    parameter int          MIN_PRESCALE     = 1,
    parameter int          IDLE_CYCLES      = 16,
    parameter int          FRAME_ERR_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        relock,
    input  logic        rx_frame_valid,
    input  logic        rx_frame_error,
    output logic [15:0] prescale,
    output logic        rx_rst,
    output logic        locked,
    output logic        busy,
    output logic        lock_error
);

    localparam int ERR_W = $clog2(FRAME_ERR_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic rxd_s, rise, fall;

    uart_rxd_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rxd_s (rxd_s),
        .rise  (rise),
        .fall  (fall)
    );

    ab_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] meas_q, meas_d;
    logic [2:0]           fall_cnt_q, fall_cnt_d;
    logic [15:0]          pend_q, pend_d;
    logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
    logic [15:0]          prescale_q, prescale_d;
    logic                 locked_q, locked_d;
    logic                 rx_rst_q, rx_rst_d;
    logic                 busy_q, busy_d;
    logic                 lock_error_q, lock_error_d;

    logic [CNT_WIDTH:0]   p_sum;
    logic [31:0]          p_val;
    logic                 check_ok;

`ifdef UART_AUTOBAUD_EDGE_CHECK_EN
    logic [CNT_WIDTH-1:0] start_w_q, start_w_d;
    logic                 start_seen_q, start_seen_d;
    logic [CNT_WIDTH+2:0] s8, m8, dev;
`endif

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        meas_d       = meas_q;
        fall_cnt_d   = fall_cnt_q;
        pend_d       = pend_q;
        err_cnt_d    = err_cnt_q;
        prescale_d   = prescale_q;
        locked_d     = locked_q;
        rx_rst_d     = rx_rst_q;
        lock_error_d = 1'b0;

        p_sum    = {1'b0, meas_q} + (CNT_WIDTH+1)'(PRESCALE_ROUND);
        p_val    = 32'(p_sum >> PRESCALE_SHIFT);
        check_ok = (p_val <= 32'd65535) && (p_val >= 32'(MIN_PRESCALE));

`ifdef UART_AUTOBAUD_EDGE_CHECK_EN
        start_w_d    = start_w_q;
        start_seen_d = start_seen_q;
        s8  = {start_w_q, 3'b000};
        m8  = {3'b000, meas_q};
        dev = (s8 >= m8) ? (s8 - m8) : (m8 - s8);
        if (dev > (m8 >> 2)) check_ok = 1'b0;
`endif

        case (state_q)
            WAIT_IDLE: begin
                if (!rxd_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_WIDTH'(IDLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_START: begin
                if (fall) begin
                    cnt_d      = '0;
                    fall_cnt_d = 3'd1;
                    state_d    = MEASURE;
`ifdef UART_AUTOBAUD_EDGE_CHECK_EN
                    start_seen_d = 1'b0;
`endif
                end
            end
            MEASURE: begin
                // cnt_d is the cycle distance from the first falling edge to the current one.
                cnt_d = cnt_q + 1'b1;
`ifdef UART_AUTOBAUD_EDGE_CHECK_EN
                if (rise && !start_seen_q) begin
                    start_w_d    = cnt_d;
                    start_seen_d = 1'b1;
                end
`endif
                if (fall) begin
                    fall_cnt_d = fall_cnt_q + 1'b1;
                    if (fall_cnt_q == 3'(SYNC_FALL_EDGES - 1)) begin
                        meas_d  = cnt_d;
                        state_d = CHECK;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    lock_error_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = WAIT_IDLE;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (check_ok) begin
                    pend_d  = p_val[15:0];
                    state_d = WAIT_STOP;
                end else begin
                    lock_error_d = 1'b1;
                    state_d      = WAIT_IDLE;
                end
            end
            WAIT_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (rise) begin
                    prescale_d = pend_q;
                    locked_d   = 1'b1;
                    rx_rst_d   = 1'b0;
                    err_cnt_d  = '0;
                    state_d    = LOCKED;
                end else if (cnt_q > (meas_q >> 2)) begin
                    lock_error_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = WAIT_IDLE;
                end
            end
            LOCKED: begin
                if (rx_frame_error) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                    if (err_cnt_q == ERR_W'(FRAME_ERR_LIMIT - 1)) begin
                        err_cnt_d = '0;
                        locked_d  = 1'b0;
                        rx_rst_d  = 1'b1;
                        cnt_d     = '0;
                        state_d   = WAIT_IDLE;
                    end
                end else if (rx_frame_valid) begin
                    err_cnt_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WAIT_IDLE;
            end
        endcase

        if (relock) begin
            state_d      = WAIT_IDLE;
            cnt_d        = '0;
            err_cnt_d    = '0;
            locked_d     = 1'b0;
            rx_rst_d     = 1'b1;
            lock_error_d = 1'b0;
        end

        busy_d = (state_d == MEASURE) || (state_d == WAIT_STOP);
    end

    // NOTE: sequential state uses non-blocking assignments only; all decisions live in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_IDLE;
            cnt_q        <= '0;
            meas_q       <= '0;
            fall_cnt_q   <= '0;
            pend_q       <= DEFAULT_PRESCALE;
            err_cnt_q    <= '0;
            prescale_q   <= DEFAULT_PRESCALE;
            locked_q     <= 1'b0;
            rx_rst_q     <= 1'b1;
            busy_q       <= 1'b0;
            lock_error_q <= 1'b0;
`ifdef UART_AUTOBAUD_EDGE_CHECK_EN
            start_w_q    <= '0;
            start_seen_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            meas_q       <= meas_d;
            fall_cnt_q   <= fall_cnt_d;
            pend_q       <= pend_d;
            err_cnt_q    <= err_cnt_d;
            prescale_q   <= prescale_d;
            locked_q     <= locked_d;
            rx_rst_q     <= rx_rst_d;
            busy_q       <= busy_d;
            lock_error_q <= lock_error_d;
`ifdef UART_AUTOBAUD_EDGE_CHECK_EN
            start_w_q    <= start_w_d;
            start_seen_q <= start_seen_d;
`endif
        end
    end

    assign prescale   = prescale_q;
    assign rx_rst     = rx_rst_q;
    assign locked     = locked_q;
    assign busy       = busy_q;
    assign lock_error = lock_error_q;

endmodule
